cnt_run_ctrl: RTL and testbench

Run controller for the 4-bit mixed-flip-flop up counter, which has only a synchronous active-high clear input and no enable. The block holds the counter cleared while idle, releases it on a START command and watches its Q bus. It re-clears the counter when a latched target value is reached, or on abort. It also checks that the counter steps by exactly +1 each RUN cycle, and keeps a completed-run tally.

---
 rtl/cnt_run_ctrl.sv | 114 +++++++++++
 tb/tb_cnt_run_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cnt_run_ctrl.sv
// Run controller for a clear-only 4-bit up counter: holds it cleared, releases it for one run, stops it at a target.
// Define CNT_RUN_CTRL_SEQ_CHECK_EN to build the +1 step checker and the ERR flag.
module cnt_run_ctrl #(
   parameter int WIDTH      = 4,
   parameter int CLR_CYCLES = 1,
   parameter int RUNS_W     = 8
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              START,
   input  logic [WIDTH-1:0]  TARGET,
   input  logic              ABORT,
   input  logic [WIDTH-1:0]  CNT_Q,
   output logic              CNT_R,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR,
   output logic [RUNS_W-1:0] RUNS
);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN} state_t;

   localparam logic [3:0] CLR_LOAD = 4'(CLR_CYCLES - 1);

   state_t           state;
   logic [WIDTH-1:0] tgt;
   logic [3:0]       clr_cnt;
   logic             seq_err;

`ifdef CNT_RUN_CTRL_SEQ_CHECK_EN
   logic [WIDTH-1:0] exp_q;
   assign seq_err = (CNT_Q != exp_q);
`else
   assign seq_err = 1'b0;
   assign ERR     = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state   <= S_IDLE;
         CNT_R   <= 1'b1;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         RUNS    <= '0;
         tgt     <= '0;
         clr_cnt <= '0;
`ifdef CNT_RUN_CTRL_SEQ_CHECK_EN
         exp_q   <= '0;
         ERR     <= 1'b0;
`endif
      end else begin
         DONE <= 1'b0;
         case (state)
            S_IDLE: begin
               if (START) begin
                  tgt     <= TARGET;
                  clr_cnt <= CLR_LOAD;
                  state   <= S_CLEAR;
                  BUSY    <= 1'b1;
                  CNT_R   <= 1'b1;
`ifdef CNT_RUN_CTRL_SEQ_CHECK_EN
                  ERR     <= 1'b0;
`endif
               end
            end
            S_CLEAR: begin
               if (ABORT) begin
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
               end else if (clr_cnt == 4'd0) begin
                  // Counter was cleared on this edge, so the first RUN cycle sees Q=0.
                  state <= S_RUN;
                  CNT_R <= 1'b0;
`ifdef CNT_RUN_CTRL_SEQ_CHECK_EN
                  exp_q <= '0;
`endif
               end else begin
                  clr_cnt <= clr_cnt - 1'b1;
               end
            end
            S_RUN: begin
               if (ABORT) begin
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
                  CNT_R <= 1'b1;
               end else if (seq_err) begin
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
                  CNT_R <= 1'b1;
`ifdef CNT_RUN_CTRL_SEQ_CHECK_EN
                  ERR   <= 1'b1;
`endif
               end else if (CNT_Q == tgt) begin
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
                  CNT_R <= 1'b1;
                  DONE  <= 1'b1;
                  RUNS  <= RUNS + 1'b1;
               end else begin
`ifdef CNT_RUN_CTRL_SEQ_CHECK_EN
                  exp_q <= exp_q + 1'b1;
`endif
               end
            end
            default: begin
               state <= S_IDLE;
               BUSY  <= 1'b0;
               CNT_R <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cnt_run_ctrl.sv
// Bench for cnt_run_ctrl: behavioural counter + run-index model, directed edge cases, then random traffic.
module tb_cnt_run_ctrl;
   localparam int W   = 4;
   localparam int CLR = 1;
   localparam int RW  = 8;
`ifdef CNT_RUN_CTRL_SEQ_CHECK_EN
   localparam bit SEQ = 1'b1;
`else
   localparam bit SEQ = 1'b0;
`endif

   logic          CLK = 1'b0, RESET_N = 1'b0, START = 1'b0, ABORT = 1'b0;
   logic [W-1:0]  TARGET = '0, cq = '0, force_val = '0;
   logic          force_en = 1'b0;
   logic [W-1:0]  cnt_q;
   logic          CNT_R, BUSY, DONE, ERR;
   logic [RW-1:0] RUNS;

   int total = 0, bad = 0, done_cnt = 0;

   // model: busy flag plus index of the current busy cycle (0..CLR-1 clear, then run index)
   bit            m_busy = 1'b0, m_err = 1'b0, m_done = 1'b0;
   int            m_k = 0;
   logic [W-1:0]  m_tgt = '0;
   logic [RW-1:0] m_runs = '0;

   assign cnt_q = force_en ? force_val : cq;

   cnt_run_ctrl #(.WIDTH(W), .CLR_CYCLES(CLR), .RUNS_W(RW)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .START(START), .TARGET(TARGET), .ABORT(ABORT),
      .CNT_Q(cnt_q), .CNT_R(CNT_R), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RUNS(RUNS));

   always #5 CLK = ~CLK;

   // the controlled counter: synchronous clear, otherwise +1
   always @(posedge CLK) cq <= CNT_R ? '0 : cq + 1'b1;

   always @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         m_busy <= 1'b0; m_k <= 0; m_tgt <= '0; m_err <= 1'b0; m_done <= 1'b0; m_runs <= '0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (START) begin
               m_busy <= 1'b1; m_k <= 0; m_tgt <= TARGET; m_err <= 1'b0;
            end
         end else if (m_k < CLR) begin
            if (ABORT) m_busy <= 1'b0;
            else       m_k <= m_k + 1;
         end else if (ABORT) begin
            m_busy <= 1'b0;
         end else if (SEQ && cnt_q != W'(m_k - CLR)) begin
            m_err <= 1'b1; m_busy <= 1'b0;
         end else if (cnt_q == m_tgt) begin
            m_done <= 1'b1; m_runs <= m_runs + 1'b1; m_busy <= 1'b0;
         end else begin
            m_k <= m_k + 1;
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (RESET_N) begin
         chk("cnt_r", int'(CNT_R), int'(!(m_busy && m_k >= CLR)));
         chk("busy",  int'(BUSY),  int'(m_busy));
         chk("done",  int'(DONE),  int'(m_done));
         chk("err",   int'(ERR),   int'(m_err));
         chk("runs",  int'(RUNS),  int'(m_runs));
         if (DONE) done_cnt <= done_cnt + 1;
      end
   end

   task automatic cyc();
      @(negedge CLK);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (BUSY && n < 100) begin cyc(); n++; end
      chk("idle_timeout", int'(BUSY), 0);
   endtask

   // asynchronous reset mid-cycle, outputs checked before any clock edge
   task automatic do_reset();
      #2 RESET_N = 1'b0;
      #1;
      chk("rst_cnt_r", int'(CNT_R), 1);
      chk("rst_busy",  int'(BUSY),  0);
      chk("rst_done",  int'(DONE),  0);
      chk("rst_err",   int'(ERR),   0);
      chk("rst_runs",  int'(RUNS),  0);
      cyc();
      RESET_N = 1'b1;
   endtask

   // start a run and pin latency (edges from accept to DONE) and the one-cycle overshoot
   task automatic run_go(input logic [W-1:0] t, input int exp_lat, input int exp_ovr, input string nm);
      int lat = 0;
      START = 1'b1; TARGET = t; cyc(); START = 1'b0;
      while (!DONE && lat < 40) begin cyc(); lat++; end
      chk({nm, "_lat"}, lat, exp_lat);
      chk({nm, "_ovr"}, int'(cnt_q), exp_ovr);
      cyc();
      chk({nm, "_clr"}, int'(cnt_q), 0);
   endtask

   initial begin
      int d0, n;
      logic [RW-1:0] exp_runs;
      repeat (2) cyc();
      RESET_N = 1'b1;
      cyc();

      run_go(4'd5, 7, 6, "t5");
      chk("t5_runs", int'(RUNS), 1);
      chk("t5_busy", int'(BUSY), 0);

      do_reset();
      run_go(4'd0, 2, 1, "t0");
      run_go(4'd15, 17, 0, "t15");
      chk("t15_runs", int'(RUNS), 2);
      chk("t15_err", int'(ERR), 0);

      // abort at Q=3 with a stray START while busy that must not relatch TARGET
      d0 = done_cnt;
      START = 1'b1; TARGET = 4'd9; cyc(); START = 1'b0;
      cyc();
      START = 1'b1; TARGET = 4'd2; cyc(); START = 1'b0;
      n = 0;
      while (cq != 4'd3 && n < 20) begin cyc(); n++; end
      ABORT = 1'b1; cyc(); ABORT = 1'b0;
      chk("abort_busy", int'(BUSY), 0);
      chk("abort_cnt_r", int'(CNT_R), 1);
      chk("abort_runs", int'(RUNS), 2);
      chk("abort_nodone", done_cnt - d0, 0);
      run_go(4'd9, 11, 10, "rerun");

      // injected sequence fault at run index 1
      d0 = done_cnt;
      START = 1'b1; TARGET = 4'd7; cyc(); START = 1'b0;
      cyc(); cyc();
      force_en = 1'b1; force_val = 4'd2; cyc(); force_en = 1'b0;
      chk("fault_err", int'(ERR), int'(SEQ));
      chk("fault_busy", int'(BUSY), int'(!SEQ));
      cyc(); cyc();
      chk("fault_sticky", int'(ERR), int'(SEQ));
      wait_idle();
      cyc();
      chk("fault_done", done_cnt - d0, SEQ ? 0 : 1);
      START = 1'b1; TARGET = 4'd0; cyc(); START = 1'b0;
      chk("fault_errclr", int'(ERR), 0);
      wait_idle();

      // random traffic with aborts, faults and asynchronous resets
      for (int i = 0; i < 3000; i++) begin
         START     = ($urandom % 6) == 0;
         TARGET    = 4'($urandom);
         ABORT     = ($urandom % 50) == 0;
         force_en  = ($urandom % 80) == 0;
         force_val = 4'($urandom);
         if (($urandom % 400) == 0) do_reset();
         else cyc();
      end
      START = 1'b0; ABORT = 1'b0; force_en = 1'b0;
      wait_idle();

      // 256 single-step runs: RUNS wraps back to 0
      do_reset();
      d0 = done_cnt;
      exp_runs = '0;
      for (int r = 0; r < 256; r++) begin
         run_go(4'd1, 3, 2, "wrap");
         exp_runs = exp_runs + 1'b1;
         chk("wrap_runs", int'(RUNS), int'(exp_runs));
      end
      chk("wrap_final", int'(RUNS), 0);
      chk("wrap_dones", done_cnt - d0, 256);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
